// File: rtl/pac_pkg.sv
// rtl/pac_pkg.sv - shared constants and types for the dot/score tracking slice
package pac_pkg;

    localparam int DEFAULT_NUM_DOTS = 10;
    localparam logic [7:0] SCORE_MAX_BCD = 8'h99;

    typedef enum logic [1:0] {
        PLAY    = 2'd0,
        COMMIT  = 2'd1,
        CLEARED = 2'd2
    } track_state_t;

endpackage

// File: rtl/bcd_sat_add.sv
// rtl/bcd_sat_add.sv - two-digit BCD plus one-digit BCD addend, saturating at 99
module bcd_sat_add
    import pac_pkg::*;
(
    input  logic [7:0] a_bcd,
    input  logic [3:0] b_bcd,
    output logic [7:0] sum_bcd
);

    logic [4:0] units_raw;
    logic [4:0] tens_raw;
    logic [3:0] units;
    logic       carry;

    always_comb begin
        units_raw = {1'b0, a_bcd[3:0]} + {1'b0, b_bcd};
        carry     = (units_raw > 5'd9);
        units     = carry ? 4'(units_raw - 5'd10) : units_raw[3:0];
        tens_raw  = {1'b0, a_bcd[7:4]} + {4'b0000, carry};
        // A tens carry means the true sum passed 99.
        sum_bcd   = (tens_raw > 5'd9) ? SCORE_MAX_BCD : {tens_raw[3:0], units};
    end

endmodule

// File: rtl/dot_score_tracker.sv
// rtl/dot_score_tracker.sv - alive-dot mask owner, per-frame dot commit and BCD score
module dot_score_tracker
    import pac_pkg::*;
#(
    parameter int         NUM_DOTS      = DEFAULT_NUM_DOTS,
    parameter logic [3:0] SCORE_PER_DOT = 4'd1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                frame_start,
    input  logic                restart,
    input  logic [NUM_DOTS-1:0] kill_10,
    output logic [NUM_DOTS-1:0] alive_10,
    output logic [7:0]          score_bcd,
    output logic                eat_pulse,
    output logic                level_clear,
    output logic                busy
);

    localparam int IDX_W = (NUM_DOTS > 1) ? $clog2(NUM_DOTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOTS - 1);

    track_state_t        state;
    logic [NUM_DOTS-1:0] pending;
    logic [NUM_DOTS-1:0] work;
    logic [IDX_W-1:0]    idx;
    logic [NUM_DOTS-1:0] live_kills;
    logic [NUM_DOTS-1:0] frame_kills;
    logic [7:0]          score_next;

    assign live_kills  = kill_10 & alive_10;
    assign frame_kills = pending | live_kills;

    bcd_sat_add u_bcd_sat_add (
        .a_bcd   (score_bcd),
        .b_bcd   (SCORE_PER_DOT),
        .sum_bcd (score_next)
    );

    assign busy        = (state == COMMIT) && !restart;
    assign eat_pulse   = (state == COMMIT) && work[idx] && !restart;
    assign level_clear = (state == CLEARED) && !restart;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            alive_10  <= '1;
            pending   <= '0;
            work      <= '0;
            score_bcd <= 8'h00;
            idx       <= '0;
            state     <= PLAY;
        end else if (restart) begin
            alive_10  <= '1;
            pending   <= '0;
            work      <= '0;
            score_bcd <= 8'h00;
            idx       <= '0;
            state     <= PLAY;
        end else begin
            // Kills gather in every state; only a PLAY frame boundary drains them.
            pending <= frame_kills;
            case (state)
                PLAY: begin
                    if (frame_start) begin
                        work     <= frame_kills;
                        pending  <= '0;
                        alive_10 <= alive_10 & ~frame_kills;
                        idx      <= '0;
                        state    <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (work[idx]) begin
                        score_bcd <= score_next;
                    end
                    if (idx == LAST_IDX) begin
                        state <= (alive_10 == '0) ? CLEARED : PLAY;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                CLEARED: begin
                    state <= CLEARED;
                end
                default: begin
                    state <= PLAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_score_tracker.sv
// tb/tb_dot_score_tracker.sv - self-checking bench for dot_score_tracker and bcd_sat_add
module tb_dot_score_tracker;

    localparam int N  = 10;
    localparam int N9 = 12;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic          Reset;
    logic          frame_start, restart;
    logic [N-1:0]  kill_10, alive_10;
    logic [7:0]    score_bcd;
    logic          eat_pulse, level_clear, busy;

    logic          frame_start9, restart9;
    logic [N9-1:0] kill9, alive9;
    logic [7:0]    score9;
    logic          eat9, clear9, busy9;

    logic [7:0]    a_bcd;
    logic [3:0]    b_bcd;
    logic [7:0]    sum_bcd;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] m_alive, m_pend, newly;
    int           m_eaten;

    dot_score_tracker #(.NUM_DOTS(N), .SCORE_PER_DOT(4'd1)) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .restart(restart),
        .kill_10(kill_10), .alive_10(alive_10), .score_bcd(score_bcd),
        .eat_pulse(eat_pulse), .level_clear(level_clear), .busy(busy)
    );

    dot_score_tracker #(.NUM_DOTS(N9), .SCORE_PER_DOT(4'd9)) dut9 (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start9), .restart(restart9),
        .kill_10(kill9), .alive_10(alive9), .score_bcd(score9),
        .eat_pulse(eat9), .level_clear(clear9), .busy(busy9)
    );

    bcd_sat_add u_bcd (.a_bcd(a_bcd), .b_bcd(b_bcd), .sum_bcd(sum_bcd));

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } bcd_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        int s;
        logic [7:0] r;
        s = (v > 99) ? 99 : v;
        r[7:4] = 4'(s / 10);
        r[3:0] = 4'(s % 10);
        return r;
    endfunction

    function automatic logic [N-1:0] rand_kill();
        logic [N-1:0] k;
        k = '0;
        if ($urandom_range(7) == 0) k[$urandom_range(N - 1)] = 1'b1;
        return k;
    endfunction

    // Counts busy cycles and eat pulses of the main instance until busy drops (bounded).
    task automatic watch(input bit noisy, output int nbusy, output int npulse);
        nbusy  = 0;
        npulse = 0;
        for (int c = 0; c < N + 5 && busy; c++) begin
            nbusy++;
            if (eat_pulse) npulse++;
            if (noisy) begin
                kill_10     = rand_kill();
                frame_start = ($urandom_range(3) == 0);
                m_pend      = m_pend | (kill_10 & m_alive);
            end
            tick();
        end
        kill_10     = '0;
        frame_start = 1'b0;
    endtask

    task automatic watch9(output int nbusy, output int npulse);
        nbusy  = 0;
        npulse = 0;
        for (int c = 0; c < N9 + 5 && busy9; c++) begin
            nbusy++;
            if (eat9) npulse++;
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bcd_vec_t vecs[12];
        int nb, np, sa, sb, ta, tb_, sdec;

        Reset = 1'b0;
        frame_start = 1'b0; restart = 1'b0; kill_10 = '0;
        frame_start9 = 1'b0; restart9 = 1'b0; kill9 = '0;
        a_bcd = 8'h00; b_bcd = 4'h0;

        vecs[0]  = '{8'h00, 4'd1, 8'h01};
        vecs[1]  = '{8'h09, 4'd1, 8'h10};
        vecs[2]  = '{8'h19, 4'd9, 8'h28};
        vecs[3]  = '{8'h98, 4'd1, 8'h99};
        vecs[4]  = '{8'h99, 4'd1, 8'h99};
        vecs[5]  = '{8'h95, 4'd9, 8'h99};
        vecs[6]  = '{8'h90, 4'd9, 8'h99};
        vecs[7]  = '{8'h45, 4'd5, 8'h50};
        vecs[8]  = '{8'h89, 4'd9, 8'h98};
        vecs[9]  = '{8'h91, 4'd9, 8'h99};
        vecs[10] = '{8'h81, 4'd9, 8'h90};
        vecs[11] = '{8'h37, 4'd0, 8'h37};
        for (int i = 0; i < 12; i++) begin
            a_bcd = vecs[i].a;
            b_bcd = vecs[i].b;
            #1;
            check($sformatf("bcd_vec%0d", i), sum_bcd, vecs[i].exp);
        end
        for (int i = 0; i < 60; i++) begin
            ta = $urandom_range(9); sa = $urandom_range(9); sb = $urandom_range(9);
            a_bcd = {4'(ta), 4'(sa)};
            b_bcd = 4'(sb);
            sdec = ta * 10 + sa + sb;
            #1;
            check("bcd_rand", sum_bcd, to_bcd(sdec));
        end
        tb_ = 0;

        // Reset state, checked while reset is held.
        #12;
        check("rst_alive", alive_10, 10'h3FF);
        check("rst_score", score_bcd, 8'h00);
        check("rst_eat", eat_pulse, 1'b0);
        check("rst_clear", level_clear, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;
        tick();

        for (int f = 0; f < 3; f++) begin
            frame_start = 1'b1; tick(); frame_start = 1'b0;
            check("idle_alive", alive_10, 10'h3FF);
            watch(1'b0, nb, np);
            check("idle_busy_len", nb, N);
            check("idle_pulses", np, 0);
            check("idle_score", score_bcd, 8'h00);
        end

        kill_10 = 10'h008;
        for (int c = 0; c < 500; c++) tick();
        kill_10 = '0;
        check("held_alive_pre", alive_10, 10'h3FF);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        check("held_alive", alive_10, 10'h3F7);
        watch(1'b0, nb, np);
        check("held_pulses", np, 1);
        check("held_score", score_bcd, 8'h01);
        kill_10 = 10'h008;
        for (int c = 0; c < 20; c++) tick();
        kill_10 = '0;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        watch(1'b0, nb, np);
        check("rekill_pulses", np, 0);
        check("rekill_score", score_bcd, 8'h01);

        restart = 1'b1; kill_10 = 10'h3FF; tick(); restart = 1'b0; kill_10 = '0;
        check("restart_alive", alive_10, 10'h3FF);
        check("restart_score", score_bcd, 8'h00);
        kill_10 = 10'h005; frame_start = 1'b1; tick(); kill_10 = '0; frame_start = 1'b0;
        check("same_cycle_alive", alive_10, 10'h3FA);
        watch(1'b0, nb, np);
        check("same_cycle_pulses", np, 2);
        check("same_cycle_score", score_bcd, 8'h02);

        // Async reset in the middle of a full-mask commit.
        restart = 1'b1; tick(); restart = 1'b0;
        kill_10 = 10'h3FF; frame_start = 1'b1; tick(); kill_10 = '0; frame_start = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check("pre_rst_busy", busy, 1'b1);
        #2 Reset = 1'b0;
        #1;
        check("async_alive", alive_10, 10'h3FF);
        check("async_score", score_bcd, 8'h00);
        check("async_busy", busy, 1'b0);
        check("async_eat", eat_pulse, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;
        np = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (eat_pulse || busy) np++;
        end
        check("post_rst_quiet", np, 0);

        // Nine points per dot on a twelve-dot instance: 90, then saturate and clear.
        kill9 = 12'h3FF; frame_start9 = 1'b1; tick(); kill9 = '0; frame_start9 = 1'b0;
        check("p9_alive", alive9, 12'hC00);
        watch9(nb, np);
        check("p9_busy_len", nb, N9);
        check("p9_pulses", np, 10);
        check("p9_score", score9, 8'h90);
        check("p9_not_clear", clear9, 1'b0);
        kill9 = 12'hC00; frame_start9 = 1'b1; tick(); kill9 = '0; frame_start9 = 1'b0;
        check("p9_alive_zero", alive9, 12'h000);
        watch9(nb, np);
        check("p9_sat_pulses", np, 2);
        check("p9_sat_score", score9, 8'h99);
        check("p9_clear", clear9, 1'b1);
        frame_start9 = 1'b1; tick(); frame_start9 = 1'b0;
        check("p9_cleared_idle", busy9, 1'b0);
        check("p9_cleared_hold", clear9, 1'b1);
        restart9 = 1'b1; tick(); restart9 = 1'b0;
        check("p9_restart_alive", alive9, 12'hFFF);
        check("p9_restart_score", score9, 8'h00);
        check("p9_restart_clear", clear9, 1'b0);

        // Randomized frames against a set-based model of dots and score.
        restart = 1'b1; tick(); restart = 1'b0;
        m_alive = '1; m_pend = '0; m_eaten = 0;
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(30, 1);
            for (int c = 0; c < len; c++) begin
                kill_10 = rand_kill();
                m_pend  = m_pend | (kill_10 & m_alive);
                tick();
            end
            kill_10 = rand_kill();
            frame_start = 1'b1;
            newly   = m_pend | (kill_10 & m_alive);
            m_alive = m_alive & ~newly;
            m_pend  = '0;
            m_eaten = m_eaten + $countones(newly);
            tick();
            frame_start = 1'b0; kill_10 = '0;
            check("rnd_alive", alive_10, m_alive);
            watch(1'b1, nb, np);
            check("rnd_busy_len", nb, N);
            check("rnd_pulses", np, $countones(newly));
            check("rnd_score", score_bcd, to_bcd(m_eaten));
            if (m_alive == '0) begin
                check("rnd_clear", level_clear, 1'b1);
                restart = 1'b1; tick(); restart = 1'b0;
                m_alive = '1; m_pend = '0; m_eaten = 0;
                check("rnd_restart_alive", alive_10, 10'h3FF);
            end else begin
                check("rnd_not_clear", level_clear, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
